ram_port_arbiter: RTL

Shares one 16x8 single-port program/data RAM between two requesters: port 0 (CPU memory path) and port 1 (program loader/debug). It accepts at most one access per transaction, with a req/gnt/rvalid handshake and round-robin arbitration. The RAM array lives inside this block and sits between the CPU control logic and storage. It replaces direct bus-to-RAM wiring when a second master is present.

---
 rtl/ram_port_arbiter.sv | 116 +++++++++++
 1 files changed

// File: rtl/ram_port_arbiter.sv
// Two-port round-robin arbiter in front of a private 16x8 single-port RAM.
// Optional macro ARB_LOCK_EN adds lock0/lock1 to pin arbitration to the last served port.
module ram_port_arbiter #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              gnt0,
  output logic              rvalid0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt1,
  output logic              rvalid1,
`ifdef ARB_LOCK_EN
  input  logic              lock0,
  input  logic              lock1,
`endif
  output logic [DATA_W-1:0] rdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t              r_state;
  logic [DATA_W-1:0]   r_mem [0:(1<<ADDR_W)-1];
  logic                r_sel, r_we, r_rr_last;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata, r_rdata;
  logic                r_gnt0, r_gnt1, r_rvalid0, r_rvalid1;
  logic                w_el0, w_el1, w_pick, w_psel;

`ifdef ARB_LOCK_EN
  logic r_srv_vld, r_lock_gnt, w_lock_act;
  // Lock only applies once some port has actually been served since reset.
  assign w_lock_act = r_srv_vld & (r_sel ? lock1 : lock0);
  assign w_el0      = req0 & ~(w_lock_act & r_sel);
  assign w_el1      = req1 & ~(w_lock_act & ~r_sel);
`else
  assign w_el0 = req0;
  assign w_el1 = req1;
`endif

  assign w_pick = w_el0 | w_el1;
  assign w_psel = (w_el0 & w_el1) ? ~r_rr_last : w_el1;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_sel     <= 1'b0;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_rdata   <= '0;
      r_rr_last <= 1'b1;
      r_gnt0    <= 1'b0;
      r_gnt1    <= 1'b0;
      r_rvalid0 <= 1'b0;
      r_rvalid1 <= 1'b0;
`ifdef ARB_LOCK_EN
      r_srv_vld  <= 1'b0;
      r_lock_gnt <= 1'b0;
`endif
    end else begin
      r_gnt0    <= 1'b0;
      r_gnt1    <= 1'b0;
      r_rvalid0 <= 1'b0;
      r_rvalid1 <= 1'b0;
      case (r_state)
        IDLE: if (w_pick) begin
          r_sel   <= w_psel;
          r_we    <= w_psel ? we1    : we0;
          r_addr  <= w_psel ? addr1  : addr0;
          r_wdata <= w_psel ? wdata1 : wdata0;
          r_gnt0  <= ~w_psel;
          r_gnt1  <= w_psel;
`ifdef ARB_LOCK_EN
          r_lock_gnt <= w_lock_act;
`endif
          r_state <= ACCESS;
        end
        ACCESS: begin
          if (!r_we) r_rdata <= r_mem[r_addr];
          r_rvalid0 <= ~r_sel;
          r_rvalid1 <= r_sel;
`ifdef ARB_LOCK_EN
          if (!r_lock_gnt) r_rr_last <= r_sel;
          r_srv_vld <= 1'b1;
`else
          r_rr_last <= r_sel;
`endif
          r_state <= RESP;
        end
        RESP:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  // Storage is never cleared; reset only suppresses an in-flight write.
  always_ff @(posedge clk) begin
    if (!reset && r_state == ACCESS && r_we) r_mem[r_addr] <= r_wdata;
  end

  assign gnt0    = r_gnt0;
  assign gnt1    = r_gnt1;
  assign rvalid0 = r_rvalid0;
  assign rvalid1 = r_rvalid1;
  assign rdata   = r_rdata;

endmodule
